// File: rtl/tpu_sched_pkg.sv
// Shared types and default sizes for the TPU scheduler slice.
package tpu_sched_pkg;

    localparam int WIDTH_ID    = 8;
    localparam int WIDTH_ISSUE = 4;
    localparam int NUM_TPU_DEF = 4;
    localparam int DEPTH_Q_DEF = 4;

    typedef logic [WIDTH_ID-1:0]    id_t;
    typedef logic [WIDTH_ISSUE-1:0] issue_no_t;

    typedef enum logic {
        IDLE,
        REQ
    } sched_state_t;

    typedef struct packed {
        id_t       thread_id;
        issue_no_t issue_no;
    } sched_entry_t;

endpackage

// File: rtl/tpu_sched_issue_queue.sv
// Issue FIFO: holds {thread id, issue no} entries waiting for a free TPU.
// Full/empty are registered from the next count so they describe the
// queue as it stands at the start of each cycle.
module tpu_sched_issue_queue
    import tpu_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_Q_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  sched_entry_t push_data,
    input  logic         pop,
    output sched_entry_t head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    sched_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push_ok;
    logic          pop_ok;

    // A push while full is dropped even if a pop lands in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    // Entry storage; contents are meaningless while empty so no reset.
    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    // Pointers, count and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/tpu_sched.sv
// TPU scheduler: queues issued threads, assigns each to a free TPU by
// round-robin, handshakes with the dispatcher, and turns TPU completion
// pulses into commit requests carrying the original issue number.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no dispatch outstanding; looking for head entry + free TPU
// REQ   | O_Req_Dispatch held with latched thread/TPU until acked
module tpu_sched
    import tpu_sched_pkg::*;
#(
    parameter int NUM_TPU = NUM_TPU_DEF,
    parameter int DEPTH_Q = DEPTH_Q_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   I_Req_Issue,
    input  logic [WIDTH_ID-1:0]    I_ThreadID,
    input  logic [WIDTH_ISSUE-1:0] I_IssueNo,
    output logic                   O_Stall,
    output logic                   O_Empty,
    output logic                   O_Req_Dispatch,
    output logic [WIDTH_ID-1:0]    O_ThreadID,
    output logic [NUM_TPU-1:0]     O_TPU_Sel,
    input  logic                   I_Ack_Dispatch,
    input  logic [NUM_TPU-1:0]     I_Done,
    output logic                   O_Req_Commit,
    output logic [WIDTH_ISSUE-1:0] O_IssueNo,
    output logic [NUM_TPU-1:0]     O_Busy
);
    localparam int PTR_W = $clog2(NUM_TPU);
    typedef logic [PTR_W-1:0] tpu_idx_t;

    sched_state_t       state;
    sched_entry_t       push_entry;
    sched_entry_t       head;
    logic               ack_fire;
    tpu_idx_t           rr_ptr;
    tpu_idx_t           sel_idx;
    tpu_idx_t           rr_idx;
    logic               rr_found;
    logic [PTR_W:0]     rr_cand;
    issue_no_t          lat_issue;
    issue_no_t          slot_q [NUM_TPU];
    logic [NUM_TPU-1:0] busy_q;
    logic [NUM_TPU-1:0] pend_q;
    logic [NUM_TPU-1:0] pend_eff;
    logic [NUM_TPU-1:0] pend_clr;
    tpu_idx_t           pend_idx;
    logic               pend_any;

    assign ack_fire = (state == REQ) && I_Ack_Dispatch;
    assign O_Busy   = busy_q;

    // Pack the incoming request into a queue entry.
    always_comb begin
        push_entry.thread_id = I_ThreadID;
        push_entry.issue_no  = I_IssueNo;
    end

    tpu_sched_issue_queue #(
        .DEPTH (DEPTH_Q)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (I_Req_Issue),
        .push_data (push_entry),
        .pop       (ack_fire),
        .head      (head),
        .full      (O_Stall),
        .empty     (O_Empty)
    );

    // First free TPU at or after the round-robin pointer, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 0; k < NUM_TPU; k++) begin
            rr_cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (rr_cand >= (PTR_W+1)'(NUM_TPU))
                rr_cand = rr_cand - (PTR_W+1)'(NUM_TPU);
            if (!rr_found && !busy_q[rr_cand[PTR_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand[PTR_W-1:0];
            end
        end
    end

    // Lowest-index pending completion, including dones arriving this cycle,
    // so a lone done commits on the very next cycle.
    always_comb begin
        pend_eff = pend_q | (I_Done & busy_q);
        pend_idx = '0;
        pend_any = 1'b0;
        for (int k = NUM_TPU - 1; k >= 0; k--) begin
            if (pend_eff[k]) begin
                pend_any = 1'b1;
                pend_idx = tpu_idx_t'(k);
            end
        end
        pend_clr           = '0;
        pend_clr[pend_idx] = pend_any;
    end

    // Dispatch FSM: latch head and target TPU, hold the request until ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            O_Req_Dispatch <= 1'b0;
            O_ThreadID     <= '0;
            O_TPU_Sel      <= '0;
            lat_issue      <= '0;
            sel_idx        <= '0;
            rr_ptr         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!O_Empty && rr_found) begin
                        state          <= REQ;
                        O_Req_Dispatch <= 1'b1;
                        O_ThreadID     <= head.thread_id;
                        lat_issue      <= head.issue_no;
                        O_TPU_Sel      <= {{(NUM_TPU-1){1'b0}}, 1'b1} << rr_idx;
                        sel_idx        <= rr_idx;
                    end
                end
                REQ: begin
                    if (I_Ack_Dispatch) begin
                        state          <= IDLE;
                        O_Req_Dispatch <= 1'b0;
                        O_TPU_Sel      <= '0;
                        rr_ptr         <= (sel_idx == tpu_idx_t'(NUM_TPU - 1)) ?
                                          '0 : sel_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue number of the thread running on each TPU; only read while busy
    // or pending, so it needs no reset.
    always_ff @(posedge clock) begin
        if (ack_fire)
            slot_q[sel_idx] <= lat_issue;
    end

    // Busy/pending bookkeeping and one commit pulse per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q       <= '0;
            pend_q       <= '0;
            O_Req_Commit <= 1'b0;
            O_IssueNo    <= '0;
        end else begin
            busy_q       <= (busy_q & ~I_Done) | (ack_fire ? O_TPU_Sel : '0);
            pend_q       <= pend_eff & ~pend_clr;
            O_Req_Commit <= pend_any;
            if (pend_any)
                O_IssueNo <= slot_q[pend_idx];
        end
    end

endmodule

// File: tb/tb_tpu_sched.sv
// Bench for tpu_sched: queue/list model of the scheduler compared every
// cycle, plus directed scenarios with literal expectations.
module tb_tpu_sched;
    localparam int NT = 4;
    localparam int DQ = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          I_Req_Issue = 1'b0;
    logic [7:0]    I_ThreadID = '0;
    logic [3:0]    I_IssueNo = '0;
    logic          I_Ack_Dispatch = 1'b0;
    logic [NT-1:0] I_Done = '0;
    logic          O_Stall, O_Empty, O_Req_Dispatch, O_Req_Commit;
    logic [7:0]    O_ThreadID;
    logic [NT-1:0] O_TPU_Sel, O_Busy;
    logic [3:0]    O_IssueNo;

    int n_checks = 0;
    int n_err    = 0;

    tpu_sched #(.NUM_TPU(NT), .DEPTH_Q(DQ)) dut (
        .clock          (clock),
        .reset          (reset),
        .I_Req_Issue    (I_Req_Issue),
        .I_ThreadID     (I_ThreadID),
        .I_IssueNo      (I_IssueNo),
        .O_Stall        (O_Stall),
        .O_Empty        (O_Empty),
        .O_Req_Dispatch (O_Req_Dispatch),
        .O_ThreadID     (O_ThreadID),
        .O_TPU_Sel      (O_TPU_Sel),
        .I_Ack_Dispatch (I_Ack_Dispatch),
        .I_Done         (I_Done),
        .O_Req_Commit   (O_Req_Commit),
        .O_IssueNo      (O_IssueNo),
        .O_Busy         (O_Busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] id;
        logic [3:0] no;
    } ent_t;

    ent_t       mq[$];
    bit         m_busy [NT];
    bit         m_old  [NT];
    bit         m_pend [NT];
    logic [3:0] m_slot [NT];
    int         m_ptr = 0;
    int         m_tpu = 0;
    bit         m_req = 0;
    logic [7:0] m_id  = '0;
    logic [3:0] m_no  = '0;
    bit         e_commit = 0;
    logic [3:0] e_issue  = '0;
    bit         m_full, m_found;
    int         m_t;
    bit         started = 0;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NT; i++) begin
            m_busy[i] = 0;
            m_pend[i] = 0;
        end
        m_ptr    = 0;
        m_req    = 0;
        e_commit = 0;
        e_issue  = '0;
    endtask

    task automatic model_step();
        ent_t e;
        m_full = (mq.size() == DQ);
        for (int i = 0; i < NT; i++) m_old[i] = m_busy[i];
        // completions on busy TPUs become pending commits
        for (int i = 0; i < NT; i++)
            if (I_Done[i] && m_old[i]) begin
                m_busy[i] = 0;
                m_pend[i] = 1;
            end
        // dispatch handshake
        if (m_req) begin
            if (I_Ack_Dispatch) begin
                void'(mq.pop_front());
                m_busy[m_tpu] = 1;
                m_slot[m_tpu] = m_no;
                m_ptr = (m_tpu + 1) % NT;
                m_req = 0;
            end
        end else if (mq.size() > 0) begin
            m_found = 0;
            for (int k = 0; k < NT; k++) begin
                m_t = (m_ptr + k) % NT;
                if (!m_found && !m_old[m_t]) begin
                    m_found = 1;
                    m_req   = 1;
                    m_tpu   = m_t;
                    m_id    = mq[0].id;
                    m_no    = mq[0].no;
                end
            end
        end
        // one commit per cycle, lowest TPU first
        e_commit = 0;
        for (int i = 0; i < NT; i++)
            if (m_pend[i] && !e_commit) begin
                e_commit  = 1;
                e_issue   = m_slot[i];
                m_pend[i] = 0;
            end
        if (I_Req_Issue && !m_full) begin
            e.id = I_ThreadID;
            e.no = I_IssueNo;
            mq.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) model_reset();
        else model_step();
        started = 1;
    end

    task automatic compare();
        logic [NT-1:0] eb;
        for (int i = 0; i < NT; i++) eb[i] = m_busy[i];
        chk("m_req", O_Req_Dispatch, m_req);
        if (m_req) begin
            chk("m_sel", O_TPU_Sel, 32'(1) << m_tpu);
            chk("m_tid", O_ThreadID, m_id);
        end
        chk("m_commit", O_Req_Commit, e_commit);
        if (e_commit) chk("m_issue", O_IssueNo, e_issue);
        chk("m_busy", O_Busy, eb);
        chk("m_stall", O_Stall, mq.size() == DQ);
        chk("m_empty", O_Empty, mq.size() == 0);
    endtask

    initial forever begin
        @(negedge clock);
        if (started) compare();
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic issue(input logic [7:0] id, input logic [3:0] no);
        I_Req_Issue = 1'b1;
        I_ThreadID  = id;
        I_IssueNo   = no;
        tick();
        I_Req_Issue = 1'b0;
    endtask

    task automatic done(input logic [NT-1:0] mask);
        I_Done = mask;
        tick();
        I_Done = '0;
    endtask

    task automatic wait_req();
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (O_Req_Dispatch) seen = 1;
            else tick();
        end
        chk("wait_req", O_Req_Dispatch, 1);
    endtask

    task automatic dispatch_one(input logic [NT-1:0] sel, input logic [7:0] id);
        wait_req();
        chk("disp_sel", O_TPU_Sel, sel);
        chk("disp_tid", O_ThreadID, id);
        I_Ack_Dispatch = 1'b1;
        tick();
        I_Ack_Dispatch = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        tick();
        tick();
        chk("rst_empty", O_Empty, 1);
        chk("rst_stall", O_Stall, 0);
        chk("rst_req", O_Req_Dispatch, 0);
        chk("rst_sel", O_TPU_Sel, 0);
        chk("rst_busy", O_Busy, 0);
        chk("rst_commit", O_Req_Commit, 0);
        reset = 1'b0;
        tick();

        // single issue, all TPUs idle
        issue(8'h12, 4'd3);
        chk("t1_empty_c1", O_Empty, 0);
        chk("t1_req_c1", O_Req_Dispatch, 0);
        tick();
        chk("t1_req_c2", O_Req_Dispatch, 1);
        chk("t1_sel_c2", O_TPU_Sel, 4'b0001);
        chk("t1_tid_c2", O_ThreadID, 8'h12);
        tick();
        tick();
        I_Ack_Dispatch = 1'b1;
        tick();
        I_Ack_Dispatch = 1'b0;
        chk("t1_busy", O_Busy, 4'b0001);
        chk("t1_req_low", O_Req_Dispatch, 0);
        done(4'b0001);
        chk("t1_commit", O_Req_Commit, 1);
        chk("t1_issue", O_IssueNo, 4'd3);
        chk("t1_busy_clr", O_Busy, 4'b0000);
        tick();
        chk("t1_commit_pulse", O_Req_Commit, 0);

        // round-robin across all four TPUs
        do_reset();
        for (int n = 0; n < 4; n++) issue(8'hA0 + 8'(n), 4'(4 + n));
        dispatch_one(4'b0001, 8'hA0);
        dispatch_one(4'b0010, 8'hA1);
        dispatch_one(4'b0100, 8'hA2);
        dispatch_one(4'b1000, 8'hA3);
        chk("t2_all_busy", O_Busy, 4'b1111);
        issue(8'hA4, 4'd9);
        tick();
        tick();
        tick();
        chk("t2_held_req", O_Req_Dispatch, 0);
        chk("t2_held_empty", O_Empty, 0);
        done(4'b0100);
        chk("t2_commit", O_Req_Commit, 1);
        chk("t2_issue", O_IssueNo, 4'd6);
        chk("t2_busy", O_Busy, 4'b1011);
        dispatch_one(4'b0100, 8'hA4);

        // queue full with every TPU busy; the request in the stall cycle is dropped
        for (int n = 0; n < 4; n++) issue(8'hC0 + 8'(n), 4'(10 + n));
        chk("t3_stall", O_Stall, 1);
        issue(8'hDD, 4'd15);
        chk("t3_stall_hold", O_Stall, 1);
        chk("t3_no_req", O_Req_Dispatch, 0);

        // simultaneous dones on TPU1 (issue 5) and TPU3 (issue 7)
        done(4'b1010);
        chk("t4_commit_a", O_Req_Commit, 1);
        chk("t4_issue_a", O_IssueNo, 4'd5);
        chk("t4_busy", O_Busy, 4'b0101);
        tick();
        chk("t4_commit_b", O_Req_Commit, 1);
        chk("t4_issue_b", O_IssueNo, 4'd7);
        dispatch_one(4'b1000, 8'hC0);
        chk("t3_stall_clr", O_Stall, 0);
        dispatch_one(4'b0010, 8'hC1);
        done(4'b0101);
        chk("t3_commit_a", O_IssueNo, 4'd4);
        tick();
        chk("t3_commit_b", O_IssueNo, 4'd9);
        dispatch_one(4'b0100, 8'hC2);
        dispatch_one(4'b0001, 8'hC3);
        for (int n = 0; n < 4; n++) tick();
        chk("t3_drop_req", O_Req_Dispatch, 0);
        chk("t3_drop_empty", O_Empty, 1);

        // spurious done on an idle TPU, then a request held for 10 cycles
        do_reset();
        done(4'b0100);
        chk("t5_no_commit", O_Req_Commit, 0);
        tick();
        chk("t5_no_commit2", O_Req_Commit, 0);
        issue(8'h5A, 4'd2);
        wait_req();
        for (int n = 0; n < 10; n++) begin
            chk("t5_hold_req", O_Req_Dispatch, 1);
            chk("t5_hold_tid", O_ThreadID, 8'h5A);
            chk("t5_hold_sel", O_TPU_Sel, 4'b0001);
            tick();
        end
        I_Ack_Dispatch = 1'b1;
        tick();
        I_Ack_Dispatch = 1'b0;
        chk("t5_busy", O_Busy, 4'b0001);

        // asynchronous reset during REQ with entries queued
        issue(8'hB0, 4'd1);
        issue(8'hB1, 4'd2);
        issue(8'hB2, 4'd3);
        wait_req();
        #1;
        reset = 1'b1;
        #1;
        chk("t6_req", O_Req_Dispatch, 0);
        chk("t6_sel", O_TPU_Sel, 0);
        chk("t6_tid", O_ThreadID, 0);
        chk("t6_commit", O_Req_Commit, 0);
        chk("t6_issue", O_IssueNo, 0);
        chk("t6_busy", O_Busy, 0);
        chk("t6_stall", O_Stall, 0);
        chk("t6_empty", O_Empty, 1);
        tick();
        tick();
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("t6_post_req", O_Req_Dispatch, 0);
            chk("t6_post_empty", O_Empty, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
